hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage 24-bit core (IF/ID/EX/MEM/WB).
- Drives the enable and flush inputs of every pipeline buffer and the registered forwarding selects used by the exec stage's operand muxes.
- Resolves load-use stalls, taken-branch flushes and multi-cycle memory waits.
- Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/fwd_sel.sv | 32 +++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Source of an EX operand: register file, MEM-stage aluOut or WB-stage result.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  // Controller sequencing state.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  // R0 is hard-wired to zero and never acts as a forwarding producer.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding match for a single EX operand; also reports the raw EX-stage hit
// so the parent can detect a load-use hazard without duplicating comparators.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int RA = 4
) (
  input  logic          useSrc_i,
  input  logic [RA-1:0] srcD_i,
  input  logic [RA-1:0] RcE_i,
  input  logic          regWriteE_i,
  input  logic [RA-1:0] RcM_i,
  input  logic          regWriteM_i,
  output logic          exHit_o,
  output fwd_sel_t      sel_o
);

  logic memHit;

  // The EX producer holds the newer value, so it outranks the MEM producer.
  always_comb begin
    exHit_o = useSrc_i && regWriteE_i && (RcE_i != RA'(REG_ZERO)) && (srcD_i == RcE_i);
    memHit  = useSrc_i && regWriteM_i && (RcM_i != RA'(REG_ZERO)) && (srcD_i == RcM_i);
    sel_o   = FWD_RF;
    if (exHit_o) begin
      sel_o = FWD_MEM;
    end else if (memHit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core: buffer
// enables/flushes, registered forwarding selects and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RA       = 4,
  parameter int BR_FLUSH = 2,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [RA-1:0] RaD,
  input  logic [RA-1:0] RbD,
  input  logic          useAD,
  input  logic          useBD,
  input  logic [RA-1:0] RcE,
  input  logic          regWriteE,
  input  logic          memToRegE,
  input  logic [RA-1:0] RcM,
  input  logic          regWriteM,
  input  logic          branchTakenE,
  input  logic          memBusy,
  output logic          enF,
  output logic          enD,
  output logic          enE,
  output logic          enM,
  output logic          enW,
  output logic          flushD,
  output logic          flushE,
  output fwd_sel_t      Fa,
  output fwd_sel_t      Fb,
  output logic [CW-1:0] stallCnt,
  output logic [CW-1:0] flushCnt
);

  // Three bits cover the full legal branch penalty range of 1..7.
  localparam int CNT_W = 3;

  hz_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  fwd_sel_t         Fa_q;
  fwd_sel_t         Fb_q;
  logic [CW-1:0]    stallCnt_q;
  logic [CW-1:0]    flushCnt_q;

  logic     frozen;
  logic     exHitA;
  logic     exHitB;
  logic     loadUse;
  logic     branchFire;
  logic     stallFire;
  logic     stallInc;
  fwd_sel_t selA;
  fwd_sel_t selB;

  fwd_sel #(.RA(RA)) uFwdA (
    .useSrc_i    (useAD),
    .srcD_i      (RaD),
    .RcE_i       (RcE),
    .regWriteE_i (regWriteE),
    .RcM_i       (RcM),
    .regWriteM_i (regWriteM),
    .exHit_o     (exHitA),
    .sel_o       (selA)
  );

  fwd_sel #(.RA(RA)) uFwdB (
    .useSrc_i    (useBD),
    .srcD_i      (RbD),
    .RcE_i       (RcE),
    .regWriteE_i (regWriteE),
    .RcM_i       (RcM),
    .regWriteM_i (regWriteM),
    .exHit_o     (exHitB),
    .sel_o       (selB)
  );

  assign frozen   = memBusy | ~en;
  assign loadUse  = memToRegE & (exHitA | exHitB);
  assign stallInc = stallFire | (memBusy & en);

  // Buffer controls, in priority order: reset, freeze, flush tail, branch, load-use.
  always_comb begin
    enF        = 1'b1;
    enD        = 1'b1;
    enE        = 1'b1;
    enM        = 1'b1;
    enW        = 1'b1;
    flushD     = 1'b0;
    flushE     = 1'b0;
    branchFire = 1'b0;
    stallFire  = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (frozen) begin
      enF = 1'b0;
      enD = 1'b0;
      enE = 1'b0;
      enM = 1'b0;
      enW = 1'b0;
    end else if (state_q == FLUSH) begin
      flushD = 1'b1;
    end else if (branchTakenE) begin
      flushD     = 1'b1;
      flushE     = 1'b1;
      branchFire = 1'b1;
    end else if (loadUse) begin
      enF       = 1'b0;
      enD       = 1'b0;
      flushE    = 1'b1;
      stallFire = 1'b1;
    end
  end

  // Sequencing FSM plus the forwarding selects for the instruction entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      Fa_q    <= FWD_RF;
      Fb_q    <= FWD_RF;
    end else if (!frozen) begin
      case (state_q)
        RUN: begin
          if (branchTakenE && (BR_FLUSH > 1)) begin
            state_q <= FLUSH;
            cnt_q   <= CNT_W'(BR_FLUSH - 1);
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
      if (enE) begin
        Fa_q <= flushE ? FWD_RF : selA;
        Fb_q <= flushE ? FWD_RF : selB;
      end
    end
  end

  // Saturating performance counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallInc && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + CW'(1);
      end
      if (branchFire && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + CW'(1);
      end
    end
  end

  assign Fa       = Fa_q;
  assign Fb       = Fb_q;
  assign stallCnt = stallCnt_q;
  assign flushCnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vector table followed by randomized
// cycles checked against a behavioural model. A second instance with 4-bit
// counters shares all inputs so counter saturation is reached quickly.
module tb_hazard_ctrl;

  localparam int BR_FLUSH = 2;

  // Packed {enF,enD,enE,enM,enW,flushD,flushE} expectations.
  localparam logic [6:0] RSTC = 7'b1111111;
  localparam logic [6:0] RUNC = 7'b1111100;
  localparam logic [6:0] FRZC = 7'b0000000;
  localparam logic [6:0] FLC  = 7'b1111110;
  localparam logic [6:0] BRC  = 7'b1111111;
  localparam logic [6:0] LUC  = 7'b0011101;

  typedef struct {
    logic       rst;
    logic       en;
    logic       memBusy;
    logic       br;
    int         raD;
    int         rbD;
    int         rcE;
    int         rcM;
    logic       ua;
    logic       ub;
    logic       rwE;
    logic       m2r;
    logic       rwM;
    logic [6:0] comb;
    int         expFa;
    int         expFb;
    int         expStall;
    int         expFlush;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] RaD;
  logic [3:0] RbD;
  logic       useAD;
  logic       useBD;
  logic [3:0] RcE;
  logic       regWriteE;
  logic       memToRegE;
  logic [3:0] RcM;
  logic       regWriteM;
  logic       branchTakenE;
  logic       memBusy;

  logic        enF, enD, enE, enM, enW, flushD, flushE;
  logic [1:0]  Fa, Fb;
  logic [15:0] stallCnt, flushCnt;

  logic        sEnF, sEnD, sEnE, sEnM, sEnW, sFlushD, sFlushE;
  logic [1:0]  sFa, sFb;
  logic [3:0]  sStallCnt, sFlushCnt;

  int checkCount;
  int errorCount;

  int flushLeft;
  int mStall;
  int mFlush;
  int mFa;
  int mFb;

  vec_t vecs[$];

  hazard_ctrl #(.RA(4), .BR_FLUSH(BR_FLUSH), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .RaD(RaD), .RbD(RbD), .useAD(useAD), .useBD(useBD),
    .RcE(RcE), .regWriteE(regWriteE), .memToRegE(memToRegE), .RcM(RcM), .regWriteM(regWriteM),
    .branchTakenE(branchTakenE), .memBusy(memBusy),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW), .flushD(flushD), .flushE(flushE),
    .Fa(Fa), .Fb(Fb), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  hazard_ctrl #(.RA(4), .BR_FLUSH(BR_FLUSH), .CW(4)) dutSmall (
    .clk(clk), .rst(rst), .en(en), .RaD(RaD), .RbD(RbD), .useAD(useAD), .useBD(useBD),
    .RcE(RcE), .regWriteE(regWriteE), .memToRegE(memToRegE), .RcM(RcM), .regWriteM(regWriteM),
    .branchTakenE(branchTakenE), .memBusy(memBusy),
    .enF(sEnF), .enD(sEnD), .enE(sEnE), .enM(sEnM), .enW(sEnW), .flushD(sFlushD), .flushE(sFlushE),
    .Fa(sFa), .Fb(sFb), .stallCnt(sStallCnt), .flushCnt(sFlushCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input logic r, input logic e, input logic mb, input logic b,
                                 input int ra, input int rb, input int ce, input int cm,
                                 input logic a, input logic bb, input logic we, input logic lm,
                                 input logic wm, input logic [6:0] c,
                                 input int fa, input int fb, input int st, input int fl);
    vec_t v;
    v.rst = r;  v.en = e;  v.memBusy = mb;  v.br = b;
    v.raD = ra; v.rbD = rb; v.rcE = ce;     v.rcM = cm;
    v.ua = a;   v.ub = bb;  v.rwE = we;     v.m2r = lm;  v.rwM = wm;
    v.comb = c; v.expFa = fa; v.expFb = fb; v.expStall = st; v.expFlush = fl;
    return v;
  endfunction

  function automatic int sat(input int val, input int maxVal);
    return (val > maxVal) ? maxVal : val;
  endfunction

  // Forwarding choice straight from the operand rules: newest producer wins.
  function automatic int fwdOf(input logic useX, input int src, input vec_t v);
    if (useX && v.rwE && v.rcE != 0 && src == v.rcE) return 1;
    if (useX && v.rwM && v.rcM != 0 && src == v.rcM) return 2;
    return 0;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    en           = v.en;
    memBusy      = v.memBusy;
    branchTakenE = v.br;
    RaD          = 4'(v.raD);
    RbD          = 4'(v.rbD);
    RcE          = 4'(v.rcE);
    RcM          = 4'(v.rcM);
    useAD        = v.ua;
    useBD        = v.ub;
    regWriteE    = v.rwE;
    memToRegE    = v.m2r;
    regWriteM    = v.rwM;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic runCycle(input vec_t v, input string tag);
    applyStimulus(v);
    #2;
    checkOutput({tag, ".comb"}, int'({enF, enD, enE, enM, enW, flushD, flushE}), int'(v.comb));
    checkOutput({tag, ".combSmall"},
                int'({sEnF, sEnD, sEnE, sEnM, sEnW, sFlushD, sFlushE}), int'(v.comb));
    @(posedge clk);
    #1;
    checkOutput({tag, ".Fa"}, int'(Fa), v.expFa);
    checkOutput({tag, ".Fb"}, int'(Fb), v.expFb);
    checkOutput({tag, ".stallCnt"}, int'(stallCnt), sat(v.expStall, 65535));
    checkOutput({tag, ".flushCnt"}, int'(flushCnt), sat(v.expFlush, 65535));
    checkOutput({tag, ".stallCntSmall"}, int'(sStallCnt), sat(v.expStall, 15));
    checkOutput({tag, ".flushCntSmall"}, int'(sFlushCnt), sat(v.expFlush, 15));
    checkOutput({tag, ".FaSmall"}, int'(sFa), v.expFa);
  endtask

  // Behavioural model: fills the expectations of v and advances the model one cycle.
  task automatic predict(input vec_t vin, output vec_t vout);
    logic frozen;
    logic lu;
    vout   = vin;
    frozen = vin.memBusy || !vin.en;
    lu     = vin.rwE && vin.m2r && vin.rcE != 0 &&
             ((vin.ua && vin.raD == vin.rcE) || (vin.ub && vin.rbD == vin.rcE));
    if (vin.rst)            vout.comb = RSTC;
    else if (frozen)        vout.comb = FRZC;
    else if (flushLeft > 0) vout.comb = FLC;
    else if (vin.br)        vout.comb = BRC;
    else if (lu)            vout.comb = LUC;
    else                    vout.comb = RUNC;
    if (vin.rst) begin
      flushLeft = 0; mFa = 0; mFb = 0; mStall = 0; mFlush = 0;
    end else if (frozen) begin
      if (vin.memBusy && vin.en) mStall++;
    end else begin
      if (flushLeft > 0) begin
        flushLeft--;
      end else if (vin.br) begin
        flushLeft = BR_FLUSH - 1;
        mFlush++;
      end else if (lu) begin
        mStall++;
      end
      if (vout.comb[0]) begin
        mFa = 0;
        mFb = 0;
      end else begin
        mFa = fwdOf(vin.ua, vin.raD, vin);
        mFb = fwdOf(vin.ub, vin.rbD, vin);
      end
    end
    vout.expFa    = mFa;
    vout.expFb    = mFb;
    vout.expStall = mStall;
    vout.expFlush = mFlush;
  endtask

  function automatic vec_t randVec();
    vec_t v;
    v = mkVec(($urandom % 64) == 0, ($urandom % 10) != 0, ($urandom % 5) == 0,
              ($urandom % 6) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              RUNC, 0, 0, 0, 0);
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t p;
    checkCount = 0;
    errorCount = 0;

    // Directed sequence: reset, forwarding priority, load-use, branch, freeze, reset abort.
    vecs.push_back(mkVec(1,1,0,0, 0,0,0,0, 0,0,0,0,0, RSTC, 0,0,0,0));
    vecs.push_back(mkVec(1,1,0,0, 0,0,0,0, 0,0,0,0,0, RSTC, 0,0,0,0));
    vecs.push_back(mkVec(0,1,0,0, 0,0,0,0, 0,0,0,0,0, RUNC, 0,0,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3,3,3,3, 1,1,1,0,1, RUNC, 1,1,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3,3,5,3, 1,1,1,0,1, RUNC, 2,2,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3,3,0,0, 1,1,1,0,1, RUNC, 0,0,0,0));
    vecs.push_back(mkVec(0,1,0,0, 0,4,4,0, 0,1,1,1,0, LUC,  0,0,1,0));
    vecs.push_back(mkVec(0,1,0,0, 0,4,0,4, 0,1,0,0,1, RUNC, 0,2,1,0));
    vecs.push_back(mkVec(0,1,0,1, 0,4,4,0, 0,1,1,1,0, BRC,  0,0,1,1));
    vecs.push_back(mkVec(0,1,0,0, 0,4,4,0, 0,1,1,1,0, FLC,  0,1,1,1));
    vecs.push_back(mkVec(0,1,0,0, 0,0,0,0, 0,0,0,0,0, RUNC, 0,0,1,1));
    vecs.push_back(mkVec(0,1,0,1, 0,0,0,0, 0,0,0,0,0, BRC,  0,0,1,2));
    vecs.push_back(mkVec(0,1,1,0, 0,0,0,0, 0,0,0,0,0, FRZC, 0,0,2,2));
    vecs.push_back(mkVec(0,1,1,0, 0,0,0,0, 0,0,0,0,0, FRZC, 0,0,3,2));
    vecs.push_back(mkVec(0,1,1,0, 0,0,0,0, 0,0,0,0,0, FRZC, 0,0,4,2));
    vecs.push_back(mkVec(0,1,0,0, 0,0,0,0, 0,0,0,0,0, FLC,  0,0,4,2));
    vecs.push_back(mkVec(0,1,0,0, 3,0,3,0, 1,0,1,0,0, RUNC, 1,0,4,2));
    vecs.push_back(mkVec(0,0,1,0, 0,0,0,0, 0,0,0,0,0, FRZC, 1,0,4,2));
    vecs.push_back(mkVec(0,0,0,0, 3,0,3,0, 1,0,1,1,0, FRZC, 1,0,4,2));
    vecs.push_back(mkVec(0,1,0,0, 3,0,3,0, 1,0,1,1,0, LUC,  0,0,5,2));
    vecs.push_back(mkVec(0,1,0,1, 3,0,3,0, 1,0,1,0,0, BRC,  0,0,5,3));
    vecs.push_back(mkVec(1,1,0,0, 0,0,0,0, 0,0,0,0,0, RSTC, 0,0,0,0));
    vecs.push_back(mkVec(0,1,0,0, 0,0,0,0, 0,0,0,0,0, RUNC, 0,0,0,0));

    foreach (vecs[i]) begin
      runCycle(vecs[i], $sformatf("vec%0d", i));
    end

    // Randomized phase against the model, starting from a clean reset.
    flushLeft = 0; mFa = 0; mFb = 0; mStall = 0; mFlush = 0;
    v = mkVec(1,1,0,0, 0,0,0,0, 0,0,0,0,0, RSTC, 0,0,0,0);
    predict(v, p);
    runCycle(p, "randRst");
    for (int i = 0; i < 400; i++) begin
      v = randVec();
      predict(v, p);
      runCycle(p, $sformatf("rand%0d", i));
    end

    // Saturation: long memory wait, then a frozen wait that must not count.
    for (int i = 0; i < 20; i++) begin
      v = randVec();
      v.rst = 1'b0; v.en = 1'b1; v.memBusy = 1'b1;
      predict(v, p);
      runCycle(p, $sformatf("satBusy%0d", i));
    end
    checkOutput("satSmallStall", int'(sStallCnt), 15);
    for (int i = 0; i < 4; i++) begin
      v = randVec();
      v.rst = 1'b0; v.en = 1'b0; v.memBusy = 1'b1;
      predict(v, p);
      runCycle(p, $sformatf("satFrozen%0d", i));
    end
    checkOutput("satSmallHold", int'(sStallCnt), 15);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
